// File: rtl/golden_check_pkg.sv
// Shared types and width helpers for the golden-vector check harness.
package golden_check_pkg;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_CHECK = 6'b000010,
        S_FETCH = 6'b000100,
        S_LOAD  = 6'b001000,
        S_START = 6'b010000,
        S_WAIT  = 6'b100000
    } state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < value) res = k + 1;
        end
        return res;
    endfunction

    // Index must be able to hold DEPTH itself, which marks the end of a run.
    function automatic int addr_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/golden_check_if.sv
// Vector-ROM read port and compute-core handshake shared by harness and its peers.
interface golden_check_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] vec_addr;
    logic              vec_ce;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] z_q;
    logic              core_start;
    logic              core_ready;
    logic              core_done;
    logic [DATA_W-1:0] core_a;
    logic [DATA_W-1:0] core_b;
    logic [DATA_W-1:0] core_return;

    modport master (
        output vec_addr, vec_ce, core_start, core_a, core_b,
        input  a_q, b_q, z_q, core_ready, core_done, core_return
    );

    modport slave (
        input  vec_addr, vec_ce, core_start, core_a, core_b,
        output a_q, b_q, z_q, core_ready, core_done, core_return
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/golden_check_harness.sv
// Replays DEPTH stored vectors through a compute core and counts results that
// differ from the stored golden value, with timeout and stop-on-first-error modes.
module golden_check_harness
    import golden_check_pkg::*;
#(
    parameter  int DATA_W   = 64,
    parameter  int DEPTH    = 20,
    parameter  int CNT_W    = 8,
    parameter  int MAX_WAIT = 1024,
    localparam int ADDR_W   = addr_width(DEPTH)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [CNT_W-1:0]  ap_return,
    input  logic              stop_on_err,
    output logic              first_err_vld,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic              timeout_seen,
    golden_check_if.master    bus
);
    localparam int WAIT_W = clog2(MAX_WAIT + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              stop_mode_q, stop_mode_d;
    logic              err_vld_q, err_vld_d;
    logic [ADDR_W-1:0] err_idx_q, err_idx_d;
    logic              timeout_q, timeout_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] core_a_q, core_a_d;
    logic [DATA_W-1:0] core_b_q, core_b_d;
    logic [DATA_W-1:0] golden_q, golden_d;
    logic              finish;
    logic              expired;
    logic              mismatch;
    logic              cnt_clr;
    logic              cnt_inc;

    assign finish  = (idx_q == ADDR_W'(DEPTH)) || (stop_mode_q && err_vld_q);
    assign expired = (wait_cnt_q == WAIT_W'(MAX_WAIT - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        stop_mode_d = stop_mode_q;
        err_vld_d   = err_vld_q;
        err_idx_d   = err_idx_q;
        timeout_d   = timeout_q;
        wait_cnt_d  = wait_cnt_q;
        core_a_d    = core_a_q;
        core_b_d    = core_b_q;
        golden_d    = golden_q;
        mismatch    = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    idx_d       = '0;
                    err_vld_d   = 1'b0;
                    err_idx_d   = '0;
                    timeout_d   = 1'b0;
                    stop_mode_d = stop_on_err;
                    cnt_clr     = 1'b1;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: state_d = finish ? S_IDLE : S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                core_a_d = bus.a_q;
                core_b_d = bus.b_q;
                golden_d = bus.z_q;
                state_d  = S_START;
            end
            S_START: begin
                if (bus.core_ready) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done arriving on the expiry cycle is still compared normally.
                if (bus.core_done || expired) begin
                    mismatch = bus.core_done ? (bus.core_return != golden_q) : 1'b1;
                    if (!bus.core_done) timeout_d = 1'b1;
                    if (mismatch) begin
                        cnt_inc = 1'b1;
                        if (!err_vld_q) begin
                            err_vld_d = 1'b1;
                            err_idx_d = idx_q;
                        end
                    end
                    idx_d   = idx_q + 1'b1;
                    state_d = S_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            stop_mode_q <= 1'b0;
            err_vld_q   <= 1'b0;
            err_idx_q   <= '0;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= '0;
            core_a_q    <= '0;
            core_b_q    <= '0;
            golden_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stop_mode_q <= stop_mode_d;
            err_vld_q   <= err_vld_d;
            err_idx_q   <= err_idx_d;
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
            core_a_q    <= core_a_d;
            core_b_q    <= core_b_d;
            golden_q    <= golden_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (ap_return)
    );

    assign ap_done        = (state_q == S_CHECK) && finish;
    assign ap_ready       = ap_done;
    assign ap_idle        = (state_q == S_IDLE) && !ap_start;
    assign first_err_vld  = err_vld_q;
    assign first_err_idx  = err_idx_q;
    assign timeout_seen   = timeout_q;
    assign bus.vec_ce     = (state_q == S_FETCH);
    assign bus.vec_addr   = (state_q == S_FETCH) ? idx_q : '0;
    assign bus.core_start = (state_q == S_START);
    assign bus.core_a     = core_a_q;
    assign bus.core_b     = core_b_q;
endmodule

// File: tb/tb_golden_check_harness.sv
// Bench for golden_check_harness: two instances (DEPTH=4/CNT_W=8 and DEPTH=6/CNT_W=2)
// driven by a ROM model and a multiplying core model, scored against a run-level model.
module tb_golden_check_harness;
    import golden_check_pkg::*;

    localparam int DW   = 64;
    localparam int MAXW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start_v = '0;
    logic       stop_mode = 1'b0;
    bit         hang = 1'b0;
    int         lat_fixed = -1;
    int         rdy_mode = 0;
    int         checks = 0;
    int         failures = 0;

    logic [DW-1:0] rom_a [8];
    logic [DW-1:0] rom_b [8];
    logic [DW-1:0] rom_z [8];

    wire [1:0]    done_w, ready_w, idle_w, fev_w, tmo_w, cstart_w, vce_w;
    wire [7:0]    ret_w   [2];
    wire [2:0]    fei_w   [2];
    wire [2:0]    vaddr_w [2];
    wire [DW-1:0] ca_w    [2];
    wire [DW-1:0] cb_w    [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int DEPTH = (g == 0) ? 4 : 6;
        localparam int CNT_W = (g == 0) ? 8 : 2;
        localparam int AW    = addr_width(DEPTH);

        golden_check_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        logic [CNT_W-1:0] ret;
        logic [AW-1:0]    fei;
        logic             busy;
        logic [3:0]       lat_cnt;
        logic [DW-1:0]    prod;

        golden_check_harness #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_WAIT(MAXW)) dut (
            .ap_clk        (clk),
            .ap_rst_n      (rst_n),
            .ap_start      (start_v[g]),
            .ap_done       (done_w[g]),
            .ap_idle       (idle_w[g]),
            .ap_ready      (ready_w[g]),
            .ap_return     (ret),
            .stop_on_err   (stop_mode),
            .first_err_vld (fev_w[g]),
            .first_err_idx (fei),
            .timeout_seen  (tmo_w[g]),
            .bus           (bus)
        );

        assign ret_w[g]    = 8'(ret);
        assign fei_w[g]    = 3'(fei);
        assign vaddr_w[g]  = 3'(bus.vec_addr);
        assign cstart_w[g] = bus.core_start;
        assign vce_w[g]    = bus.vec_ce;
        assign ca_w[g]     = bus.core_a;
        assign cb_w[g]     = bus.core_b;

        // Vector ROM with one cycle of read latency.
        always @(posedge clk) begin
            if (bus.vec_ce) begin
                bus.a_q <= rom_a[bus.vec_addr];
                bus.b_q <= rom_b[bus.vec_addr];
                bus.z_q <= rom_z[bus.vec_addr];
            end
        end

        always @(negedge clk) begin
            bus.core_ready <= (rdy_mode == 1) ? 1'b1 :
                              (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end

        // Core multiplies a*b and answers after a chosen number of extra cycles.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy    <= 1'b0;
                lat_cnt <= '0;
                prod    <= '0;
            end else if (bus.core_start && bus.core_ready) begin
                busy    <= !hang;
                lat_cnt <= (lat_fixed >= 0) ? 4'(lat_fixed) : 4'($urandom_range(0, 3));
                prod    <= bus.core_a * bus.core_b;
            end else if (busy) begin
                if (lat_cnt == 0) busy <= 1'b0;
                else              lat_cnt <= lat_cnt - 1'b1;
            end
        end

        assign bus.core_done   = busy && (lat_cnt == 0);
        assign bus.core_return = prod;
    end

    task automatic fill_vectors(input logic [7:0] err_mask);
        for (int k = 0; k < 8; k++) begin
            rom_a[k] = {$urandom, $urandom};
            rom_b[k] = {$urandom, $urandom};
            rom_z[k] = rom_a[k] * rom_b[k];
            if (err_mask[k]) rom_z[k] = rom_z[k] ^ (64'd1 << $urandom_range(0, 63));
        end
    endtask

    // Whole-run expectation from the vector list: which vectors are wrong, where to stop.
    function automatic void model(input int g, input bit stop, output int e_ret,
                                  output int e_idx, output bit e_vld, output bit e_tmo);
        int depth;
        int cmax;
        int cnt;
        logic [DW-1:0] expect_prod;
        depth = (g == 0) ? 4 : 6;
        cmax  = (g == 0) ? 255 : 3;
        cnt   = 0;
        e_idx = 0;
        e_vld = 1'b0;
        e_tmo = 1'b0;
        for (int k = 0; k < depth; k++) begin
            if (stop && e_vld) break;
            expect_prod = rom_a[k] * rom_b[k];
            if (hang || (rom_z[k] != expect_prod)) begin
                cnt++;
                if (!e_vld) begin
                    e_vld = 1'b1;
                    e_idx = k;
                end
            end
            if (hang) e_tmo = 1'b1;
        end
        e_ret = (cnt > cmax) ? cmax : cnt;
    endfunction

    // Pulses ap_start and counts cycles from the first CHECK cycle to ap_done.
    task automatic run_dut(input int g, input int budget, input int inject_at,
                           output int cycles, output bit timed_out);
        @(negedge clk);
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        cycles    = 0;
        timed_out = 1'b1;
        while (cycles < budget) begin
            if (done_w[g]) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
            cycles++;
            if (cycles == inject_at) begin
                start_v[g] = 1'b1;
                stop_mode  = !stop_mode;
            end else if (cycles == inject_at + 1) begin
                start_v[g] = 1'b0;
                stop_mode  = !stop_mode;
            end
        end
        start_v[g] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_v = '0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({ret_w[g], fei_w[g], vaddr_w[g], done_w[g], ready_w[g], fev_w[g],
                 tmo_w[g], cstart_w[g], vce_w[g]} !== 23'd0) begin
                failures++;
                $display("[TB] FAIL reset_outputs[%0d]: ret=%0d idx=%0d addr=%0d done=%0b rdy=%0b vld=%0b tmo=%0b cs=%0b ce=%0b, all required 0",
                         g, ret_w[g], fei_w[g], vaddr_w[g], done_w[g], ready_w[g], fev_w[g], tmo_w[g], cstart_w[g], vce_w[g]);
            end
            checks++;
            if ((ca_w[g] | cb_w[g]) !== '0) begin
                failures++;
                $display("[TB] FAIL reset_operands[%0d]: core_a=%h core_b=%h required 0", g, ca_w[g], cb_w[g]);
            end
        end
        checks++;
        if (idle_w !== 2'b11) begin
            failures++;
            $display("[TB] FAIL reset_idle_low_start: got %b required 11", idle_w);
        end
        start_v = 2'b11;
        #1;
        checks++;
        if (idle_w !== 2'b00 || done_w !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_idle_follows_start: idle=%b done=%b required 00/00", idle_w, done_w);
        end
        start_v = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_all_match();
        int cyc;
        bit hit;
        rdy_mode  = 1;
        hang      = 1'b0;
        stop_mode = 1'b0;
        fill_vectors(8'h00);
        for (int lat = 0; lat < 4; lat++) begin
            lat_fixed = lat;
            run_dut(0, 200, -1, cyc, hit);
            checks++;
            if (hit || cyc != 4 * (5 + lat)) begin
                failures++;
                $display("[TB] FAIL all_match_latency: got %0d cycles required %0d", cyc, 4 * (5 + lat));
            end
            checks++;
            if (ret_w[0] !== 8'd0 || fev_w[0] !== 1'b0 || tmo_w[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL all_match_result: ret=%0d vld=%0b tmo=%0b required 0/0/0", ret_w[0], fev_w[0], tmo_w[0]);
            end
            checks++;
            if (ready_w[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL all_match_ready: got %0b required 1", ready_w[0]);
            end
            @(negedge clk);
            checks++;
            if (done_w[0] !== 1'b0 || idle_w[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL done_one_cycle: done=%0b idle=%0b required 0/1", done_w[0], idle_w[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit hit;
        rdy_mode  = 0;
        lat_fixed = -1;
        stop_mode = 1'b0;
        fill_vectors(8'b0000_1010);
        // A stray start with stop_on_err flipped mid-run must not disturb the run.
        run_dut(0, 300, 6, cyc, hit);
        checks++;
        if (hit || ret_w[0] !== 8'd2 || fei_w[0] !== 3'd1 || fev_w[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL two_errors: ret=%0d idx=%0d vld=%0b hung=%0b required 2/1/1/0", ret_w[0], fei_w[0], fev_w[0], hit);
        end
        stop_mode = 1'b1;
        run_dut(0, 300, -1, cyc, hit);
        checks++;
        if (hit || ret_w[0] !== 8'd1 || fei_w[0] !== 3'd1 || fev_w[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stop_on_err: ret=%0d idx=%0d vld=%0b hung=%0b required 1/1/1/0", ret_w[0], fei_w[0], fev_w[0], hit);
        end
        stop_mode = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ret_w[0] !== 8'd1 || fei_w[0] !== 3'd1 || fev_w[0] !== 1'b1 || idle_w[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_after_done: ret=%0d idx=%0d vld=%0b idle=%0b required 1/1/1/1", ret_w[0], fei_w[0], fev_w[0], idle_w[0]);
        end
    endtask

    task automatic test_stop_latency();
        int cyc;
        bit hit;
        rdy_mode  = 1;
        lat_fixed = 0;
        stop_mode = 1'b1;
        fill_vectors(8'b0000_1010);
        run_dut(0, 200, -1, cyc, hit);
        stop_mode = 1'b0;
        checks++;
        if (hit || cyc != 10 || ret_w[0] !== 8'd1) begin
            failures++;
            $display("[TB] FAIL stop_latency: cycles=%0d ret=%0d required 10/1", cyc, ret_w[0]);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit hit;
        rdy_mode  = 1;
        hang      = 1'b1;
        stop_mode = 1'b0;
        fill_vectors(8'h00);
        run_dut(0, 200, -1, cyc, hit);
        hang = 1'b0;
        checks++;
        if (hit || cyc != 4 * (4 + MAXW)) begin
            failures++;
            $display("[TB] FAIL timeout_latency: got %0d cycles required %0d", cyc, 4 * (4 + MAXW));
        end
        checks++;
        if (ret_w[0] !== 8'd4 || tmo_w[0] !== 1'b1 || fev_w[0] !== 1'b1 || fei_w[0] !== 3'd0) begin
            failures++;
            $display("[TB] FAIL timeout_result: ret=%0d tmo=%0b vld=%0b idx=%0d required 4/1/1/0", ret_w[0], tmo_w[0], fev_w[0], fei_w[0]);
        end
    endtask

    task automatic test_done_vs_timeout();
        int cyc;
        bit hit;
        rdy_mode  = 1;
        lat_fixed = MAXW - 1;
        stop_mode = 1'b0;
        fill_vectors(8'b0000_0100);
        run_dut(0, 200, -1, cyc, hit);
        checks++;
        if (hit || cyc != 4 * (4 + MAXW) || ret_w[0] !== 8'd1 || fei_w[0] !== 3'd2 || tmo_w[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_beats_timeout: cycles=%0d ret=%0d idx=%0d tmo=%0b required %0d/1/2/0",
                     cyc, ret_w[0], fei_w[0], tmo_w[0], 4 * (4 + MAXW));
        end
    endtask

    task automatic test_saturation();
        int cyc;
        bit hit;
        rdy_mode  = 0;
        lat_fixed = -1;
        stop_mode = 1'b0;
        fill_vectors(8'h3F);
        run_dut(1, 300, -1, cyc, hit);
        checks++;
        if (hit || ret_w[1] !== 8'd3 || fei_w[1] !== 3'd0 || fev_w[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL saturation: ret=%0d idx=%0d vld=%0b required 3/0/1", ret_w[1], fei_w[1], fev_w[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit hit;
        int guard;
        rdy_mode  = 1;
        hang      = 1'b1;
        stop_mode = 1'b0;
        fill_vectors(8'h00);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        // Cycle 19 falls inside the WAIT phase of the second vector.
        repeat (19) @(negedge clk);
        checks++;
        if (ret_w[0] !== 8'd1 || tmo_w[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset_state: ret=%0d tmo=%0b required 1/1", ret_w[0], tmo_w[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ret_w[0], fei_w[0], vaddr_w[0], done_w[0], ready_w[0], fev_w[0], tmo_w[0],
             cstart_w[0], vce_w[0]} !== 23'd0 || (ca_w[0] | cb_w[0]) !== '0 || idle_w[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_wait: ret=%0d tmo=%0b ca=%h idle=%0b required 0/0/0/1", ret_w[0], tmo_w[0], ca_w[0], idle_w[0]);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        hang     = 1'b0;
        rdy_mode = 2;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        guard = 0;
        while (cstart_w[0] !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        checks++;
        if (cstart_w[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_held: core_start=%0b required 1", cstart_w[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cstart_w[0] !== 1'b0 || idle_w[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_start: core_start=%0b idle=%0b required 0/1", cstart_w[0], idle_w[0]);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 0;
        fill_vectors(8'b0000_0100);
        run_dut(0, 300, -1, cyc, hit);
        checks++;
        if (hit || ret_w[0] !== 8'd1 || fei_w[0] !== 3'd2 || tmo_w[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL run_after_reset: ret=%0d idx=%0d tmo=%0b hung=%0b required 1/2/0/0", ret_w[0], fei_w[0], tmo_w[0], hit);
        end
    endtask

    task automatic test_random();
        int cyc;
        bit hit;
        int g;
        int e_ret;
        int e_idx;
        bit e_vld;
        bit e_tmo;
        rdy_mode  = 0;
        lat_fixed = -1;
        for (int it = 0; it < 12; it++) begin
            g         = $urandom_range(0, 1);
            stop_mode = 1'($urandom_range(0, 1));
            hang      = ($urandom_range(0, 5) == 0);
            fill_vectors(8'($urandom));
            model(g, stop_mode, e_ret, e_idx, e_vld, e_tmo);
            run_dut(g, 400, -1, cyc, hit);
            checks++;
            if (hit || ret_w[g] !== 8'(e_ret)) begin
                failures++;
                $display("[TB] FAIL random_ret[%0d]: got %0d required %0d (hung=%0b)", it, ret_w[g], e_ret, hit);
            end
            checks++;
            if (fev_w[g] !== e_vld || tmo_w[g] !== e_tmo) begin
                failures++;
                $display("[TB] FAIL random_flags[%0d]: vld=%0b tmo=%0b required %0b/%0b", it, fev_w[g], tmo_w[g], e_vld, e_tmo);
            end
            if (e_vld) begin
                checks++;
                if (fei_w[g] !== 3'(e_idx)) begin
                    failures++;
                    $display("[TB] FAIL random_idx[%0d]: got %0d required %0d", it, fei_w[g], e_idx);
                end
            end
        end
        hang      = 1'b0;
        stop_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_match();
        test_back_to_back();
        test_stop_latency();
        test_timeout();
        test_done_vs_timeout();
        test_saturation();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
